// File: rtl/arm_fetch.sv
// ---------------------------------------------------------------------------
// arm_fetch
//
// Instruction fetch unit feeding arm_decode. Holds the fetch PC, issues word
// requests to instruction memory, buffers returned words and hands them to
// decode together with their address and the ARM-visible PC (address + 8).
// A redirect from the register-file side (pc_we) restarts fetch at pc_in and
// discards everything already buffered.
//
// Optional feature macro: ARM_FETCH_PREFETCH_BUF_EN
//   defined   : 2-entry buffer, fetch continues while decode holds an entry
//   undefined : 1-entry buffer, one instruction every 2 cycles when streaming
//
// Ports
//   clk         in   1   clock, all state on rising edge
//   reset       in   1   synchronous, active-high
//   imem_req    out  1   memory request valid (registered state decode)
//   imem_addr   out  32  word address requested, bits [1:0] always 0
//   imem_ack    in   1   memory accepts request, data returned same cycle
//   imem_rdata  in   32  instruction word, valid with imem_ack
//   pc_we       in   1   redirect strobe (branch, BL, write to R15)
//   pc_in       in   32  redirect target (low two bits ignored)
//   inst_valid  out  1   inst/inst_addr/pc_out hold a valid instruction
//   inst_ready  in   1   decode consumes inst this cycle
//   inst        out  32  instruction word
//   inst_addr   out  32  address of inst
//   pc_out      out  32  inst_addr + 8 (R15 as seen by the instruction)
//   dbg_state   out  2   current FSM state (0 IDLE, 1 REQ, 2 STALL)
//
// Handshakes: a transfer happens in a cycle where valid and ready/ack are
// both 1 at the rising edge. Once raised, valid and its payload stay stable
// until that transfer completes or a redirect/reset cancels it. imem_ack is
// only meaningful while imem_req=1; decode pops when inst_valid && inst_ready.
// ---------------------------------------------------------------------------
module arm_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        pc_we,
    input  logic [31:0] pc_in,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic [31:0] pc_out,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

`ifdef ARM_FETCH_PREFETCH_BUF_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    logic [1:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic [1:0]  r_count;
    logic [31:0] r_word0;
    logic [31:0] r_addr0;
`ifdef ARM_FETCH_PREFETCH_BUF_EN
    logic [31:0] r_word1;
    logic [31:0] r_addr1;
`endif

    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_count_next;
    logic        w_unused_pc_lsb;

    // A redirect in the same cycle discards the returned word.
    assign w_push = (r_state == S_REQ) && imem_ack && !pc_we;
    assign w_pop  = inst_valid && inst_ready;

    // Word alignment is enforced on redirect; the dropped bits feed nothing.
    assign w_unused_pc_lsb = ^pc_in[1:0];

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_count    <= 2'd0;
            r_word0    <= 32'd0;
            r_addr0    <= 32'd0;
`ifdef ARM_FETCH_PREFETCH_BUF_EN
            r_word1    <= 32'd0;
            r_addr1    <= 32'd0;
`endif
        end else begin
            // ---------------- FSM and fetch PC ----------------
            if (pc_we) begin
                r_state    <= S_REQ;
                r_fetch_pc <= {pc_in[31:2], 2'b00};
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_REQ;
                    S_REQ: begin
                        if (w_push) begin
                            r_fetch_pc <= r_fetch_pc + 32'd4;
                            if (w_count_next == DEPTH) begin
                                r_state <= S_STALL;
                            end
                        end
                    end
                    S_STALL: begin
                        if (w_pop) begin
                            r_state <= S_REQ;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            // ---------------- buffer occupancy ----------------
            // The pop in a redirect cycle is still delivered to decode; the
            // flush only clears what is left afterwards.
            r_count <= pc_we ? 2'd0 : w_count_next;

            // ---------------- buffer data ----------------
`ifdef ARM_FETCH_PREFETCH_BUF_EN
            if (w_pop) begin
                // Head leaves; the second entry (or the incoming word when
                // only one was held) becomes the new head.
                if (w_push && r_count == 2'd1) begin
                    r_word0 <= imem_rdata;
                    r_addr0 <= r_fetch_pc;
                end else begin
                    r_word0 <= r_word1;
                    r_addr0 <= r_addr1;
                end
                if (w_push && r_count == 2'd2) begin
                    r_word1 <= imem_rdata;
                    r_addr1 <= r_fetch_pc;
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_word0 <= imem_rdata;
                    r_addr0 <= r_fetch_pc;
                end else begin
                    r_word1 <= imem_rdata;
                    r_addr1 <= r_fetch_pc;
                end
            end
`else
            // Single entry: a push only happens when the slot is empty or is
            // being popped in the same cycle.
            if (w_push) begin
                r_word0 <= imem_rdata;
                r_addr0 <= r_fetch_pc;
            end
`endif
        end
    end

    assign imem_req   = (r_state == S_REQ);
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = (r_count != 2'd0);
    assign inst       = r_word0;
    assign inst_addr  = r_addr0;
    // Modulo 2^32: an instruction at 0xFFFF_FFFC reads R15 as 0x0000_0004.
    assign pc_out     = r_addr0 + 32'd8;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_arm_fetch.sv
// ---------------------------------------------------------------------------
// tb_arm_fetch
//
// Self-checking bench for arm_fetch. The scoreboard block models the fetch
// pointer and memory, queues expected {addr, word} for every accepted fetch,
// and compares each instruction decode consumes. Directed checks in the main
// sequence cover reset values, latency, stall, redirect, alignment, wrap and
// reset in mid-operation.
// ---------------------------------------------------------------------------
module tb_arm_fetch;

`ifdef ARM_FETCH_PREFETCH_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        pc_we = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic [31:0] pc_out;
    logic [1:0]  dbg_state;

    arm_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_we      (pc_we),
        .pc_in      (pc_in),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_addr  (inst_addr),
        .pc_out     (pc_out),
        .dbg_state  (dbg_state)
    );

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'hE201_1002;
            32'h0000_0004: mem_word = 32'hE3C8_9CFF;
            32'h0000_0008: mem_word = 32'hE083_4002;
            default:       mem_word = 32'hE1A0_0000 | {16'h0000, a[15:0]};
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    logic [31:0] exp_fetch_pc = RESET_PC;
    logic [31:0] pop_addr_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_inst_q[$];
    int          pop_cyc_q[$];

    always @(negedge clk) begin
        logic [63:0] e;
        if (reset) begin
            exp_q.delete();
            exp_fetch_pc = RESET_PC;
        end else begin
            if (inst_valid && inst_ready) begin
                pop_addr_q.push_back(inst_addr);
                pop_pc_q.push_back(pc_out);
                pop_inst_q.push_back(inst);
                pop_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL mon_unexpected_pop: got addr %h, required no instruction", inst_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_inst_addr", inst_addr, e[63:32]);
                    chk("mon_inst", inst, e[31:0]);
                    chk("mon_pc_out", pc_out, e[63:32] + 32'd8);
                end
            end
            if (pc_we) begin
                exp_q.delete();
                exp_fetch_pc = {pc_in[31:2], 2'b00};
            end else if (imem_req && imem_ack) begin
                chk("mem_req_addr", imem_addr, exp_fetch_pc);
                exp_q.push_back({exp_fetch_pc, mem_word(exp_fetch_pc)});
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_pops();
        pop_addr_q.delete();
        pop_pc_q.delete();
        pop_inst_q.delete();
        pop_cyc_q.delete();
    endtask

    task automatic redirect(input logic [31:0] target);
        pc_we = 1'b1;
        pc_in = target;
        step();
        pc_we = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_imem_req"},   {31'd0, imem_req},   32'd0);
        chk({tag, "_imem_addr"},  imem_addr,           RESET_PC);
        chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_inst"},       inst,                32'd0);
        chk({tag, "_inst_addr"},  inst_addr,           32'd0);
        chk({tag, "_pc_out"},     pc_out,              32'd8);
        chk({tag, "_state"},      {30'd0, dbg_state},  32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int start_cyc;
        int found;
        logic [1:0] exp_req[5];

        // ---- reset and streaming ----
        run(3);
        check_reset_values("rst");
        clear_pops();
        reset      = 1'b0;
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        start_cyc  = cyc;
        chk("t1_cyc0_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("t1_cyc1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_cyc1_addr", imem_addr, RESET_PC);
        step();
        chk("t1_cyc2_valid", {31'd0, inst_valid}, 32'd1);
        chk("t1_cyc2_addr", inst_addr, RESET_PC);
        for (int k = 0; k < 12; k++) begin
            if (pop_addr_q.size() >= 3) break;
            step();
        end
        imem_ack = 1'b0;
        run(4);
        chk("t1_pop_count", {31'd0, pop_addr_q.size() >= 3}, 32'd1);
        if (pop_addr_q.size() >= 3) begin
            chk("t1_addr0", pop_addr_q[0], 32'h0);
            chk("t1_addr1", pop_addr_q[1], 32'h4);
            chk("t1_addr2", pop_addr_q[2], 32'h8);
            chk("t1_inst0", pop_inst_q[0], 32'hE201_1002);
            chk("t1_inst1", pop_inst_q[1], 32'hE3C8_9CFF);
            chk("t1_inst2", pop_inst_q[2], 32'hE083_4002);
            chk("t1_pc0", pop_pc_q[0], 32'd8);
            chk("t1_pc1", pop_pc_q[1], 32'd12);
            chk("t1_pc2", pop_pc_q[2], 32'd16);
            chk("t1_first_lat", pop_cyc_q[0] - start_cyc, 32'd2);
            chk("t1_gap01", pop_cyc_q[1] - pop_cyc_q[0], (DEPTH == 2) ? 32'd1 : 32'd2);
            chk("t1_gap12", pop_cyc_q[2] - pop_cyc_q[1], (DEPTH == 2) ? 32'd1 : 32'd2);
        end

        // ---- decode stall ----
        redirect(32'h40);
        inst_ready = 1'b0;
        imem_ack   = 1'b1;
        exp_req    = (DEPTH == 2) ? '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0}
                                  : '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
        chk("t2_first_addr", imem_addr, 32'h40);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_req_%0d", i), {31'd0, imem_req}, {30'd0, exp_req[i]});
            if (i >= 1) begin
                chk($sformatf("t2_valid_%0d", i), {31'd0, inst_valid}, 32'd1);
                chk($sformatf("t2_hold_addr_%0d", i), inst_addr, 32'h40);
                chk($sformatf("t2_hold_inst_%0d", i), inst, 32'hE1A0_0040);
            end
            step();
        end
        inst_ready = 1'b1;
        step();
        chk("t2_resume_req", {31'd0, imem_req}, 32'd1);
        chk("t2_resume_addr", imem_addr, 32'h40 + 32'(4 * DEPTH));
        imem_ack = 1'b0;
        run(4);

        // ---- branch redirect while fetching 0x0C ----
        redirect(32'h0);
        imem_ack = 1'b1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (imem_req && imem_addr == 32'hC) begin
                found = 1;
                break;
            end
            step();
        end
        chk("t3_reach_0c", found, 32'd1);
        redirect(32'h34);
        clear_pops();
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h34);
        chk("t3_flushed", {31'd0, inst_valid}, 32'd0);
        run(3);
        imem_ack = 1'b0;
        run(4);
        chk("t3_pop_count", {31'd0, pop_addr_q.size() >= 1}, 32'd1);
        if (pop_addr_q.size() >= 1) begin
            chk("t3_first_addr", pop_addr_q[0], 32'h34);
            chk("t3_first_pc", pop_pc_q[0], 32'h3C);
            chk("t3_first_inst", pop_inst_q[0], 32'hE1A0_0034);
        end
        found = 0;
        foreach (pop_addr_q[i]) if (pop_addr_q[i] == 32'hC) found++;
        chk("t3_no_0c", found, 32'd0);

        // ---- redirect with ack and full buffer ----
        inst_ready = 1'b0;
        imem_ack   = 1'b1;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (!imem_req && inst_valid) begin
                found = 1;
                break;
            end
        end
        chk("t4_reach_stall", found, 32'd1);
        chk("t4_in_stall", {30'd0, dbg_state}, 32'd2);
        redirect(32'h200);
        chk("t4_flushed", {31'd0, inst_valid}, 32'd0);
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        chk("t4_addr", imem_addr, 32'h200);
        chk("t4_state", {30'd0, dbg_state}, 32'd1);
        clear_pops();
        inst_ready = 1'b1;
        run(2);
        imem_ack = 1'b0;
        run(4);
        chk("t4_pop_count", {31'd0, pop_addr_q.size() >= 1}, 32'd1);
        if (pop_addr_q.size() >= 1) chk("t4_first_addr", pop_addr_q[0], 32'h200);

        // ---- misaligned target and wrap-around ----
        redirect(32'h103);
        chk("t5_align_req", {31'd0, imem_req}, 32'd1);
        chk("t5_align_addr", imem_addr, 32'h100);
        redirect(32'hFFFF_FFFC);
        chk("t5_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack   = 1'b1;
        inst_ready = 1'b0;
        step();
        imem_ack = 1'b0;
        chk("t5_wrap_valid", {31'd0, inst_valid}, 32'd1);
        chk("t5_wrap_inst_addr", inst_addr, 32'hFFFF_FFFC);
        chk("t5_wrap_pc_out", pc_out, 32'h4);
        chk("t5_wrap_inst", inst, 32'hE1A0_FFFC);
        inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (imem_req) break;
            step();
        end
        chk("t5_next_req", {31'd0, imem_req}, 32'd1);
        chk("t5_next_addr", imem_addr, 32'h0);
        step();

        // ---- reset mid-request ----
        inst_ready = 1'b0;
        imem_ack   = 1'b1;
        step();
        chk("t6_pre_valid", {31'd0, inst_valid}, 32'd1);
        reset = 1'b1;
        step();
        check_reset_values("t6");
        reset      = 1'b0;
        inst_ready = 1'b1;
        chk("t6_cyc0_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("t6_cyc1_req", {31'd0, imem_req}, 32'd1);
        chk("t6_cyc1_addr", imem_addr, RESET_PC);
        step();
        chk("t6_cyc2_valid", {31'd0, inst_valid}, 32'd1);
        chk("t6_cyc2_addr", inst_addr, 32'h0);
        chk("t6_cyc2_inst", inst, 32'hE201_1002);
        chk("t6_cyc2_pc", pc_out, 32'h8);
        imem_ack = 1'b0;
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
